// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG collector.
package trng_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StCollect,
        StStall
    } collector_state_t;

    localparam int unsigned DefWordWidth = 32;
    localparam int unsigned DefFifoDepth = 4;
    localparam int unsigned DefSampleDiv = 4;
    localparam int unsigned DefWarmup    = 16;
    localparam int unsigned DefRepLimit  = 8;

    // Von Neumann pair {first, second} -> emitted bit
    localparam logic [1:0] PairEmitZero = 2'b01;
    localparam logic [1:0] PairEmitOne  = 2'b10;

endpackage

// File: rtl/trng_word_fifo.sv
// Small synchronous word FIFO; a push into a full FIFO is accepted only alongside a pop.
module trng_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [PtrW:0]     count_q;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/trng_collector.sv
// Samples the TRNG bit at a divided rate, von Neumann debiases, packs words into a FIFO
// and watches raw samples for stuck runs.
module trng_collector
    import trng_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DefWordWidth,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned SAMPLE_DIV = DefSampleDiv,
    parameter int unsigned WARMUP     = DefWarmup,
    parameter int unsigned REP_LIMIT  = DefRepLimit
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    output logic                          trng_en,
    input  logic                          trng_in,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [WORD_WIDTH-1:0]         rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          health_fail
);

    localparam int unsigned DivW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned WarmW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int unsigned RunW  = $clog2(REP_LIMIT + 1);
    localparam int unsigned BitW  = $clog2(WORD_WIDTH + 1);

    collector_state_t        state_q, state_d;
    logic [DivW-1:0]         div_q, div_d;
    logic [WarmW-1:0]        warm_q, warm_d;
    logic                    pair_vld_q, pair_vld_d;
    logic                    pair_bit_q, pair_bit_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic [BitW-1:0]         bitcnt_q, bitcnt_d;
    logic                    prev_q, prev_d;
    logic [RunW-1:0]         run_q, run_d;
    logic                    fail_q, fail_d;

    logic                    tick, running;
    logic                    emit, emit_bit;
    logic [WORD_WIDTH-1:0]   word_shift;
    logic [BitW-1:0]         bitcnt_inc;
    logic                    push, pop, push_ok;
    logic                    fifo_full, fifo_empty;

    assign running    = (state_q == StWarmup) || (state_q == StCollect);
    assign tick       = running && (div_q == DivW'(SAMPLE_DIV - 1));
    assign rd_valid   = !fifo_empty;
    assign pop        = rd_valid && rd_ready;
    assign push_ok    = !fifo_full || pop;
    assign word_shift = {word_q[WORD_WIDTH-2:0], emit_bit};
    assign bitcnt_inc = bitcnt_q + BitW'(1);
    assign health_fail = fail_q;

    always_comb begin
        emit     = 1'b0;
        emit_bit = 1'b0;
        if (pair_vld_q) begin
            case ({pair_bit_q, trng_in})
                PairEmitZero: emit = 1'b1;
                PairEmitOne: begin
                    emit     = 1'b1;
                    emit_bit = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        warm_d     = warm_q;
        pair_vld_d = pair_vld_q;
        pair_bit_d = pair_bit_q;
        word_d     = word_q;
        bitcnt_d   = bitcnt_q;
        prev_d     = prev_q;
        run_d      = run_q;
        fail_d     = fail_q;
        push       = 1'b0;
        trng_en    = 1'b0;

        if (running) begin
            div_d = tick ? '0 : div_q + DivW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StWarmup;
                    div_d   = '0;
                    warm_d  = WarmW'(WARMUP);
                    run_d   = '0;
                    fail_d  = 1'b0;
                end
            end
            StWarmup: begin
                trng_en = 1'b1;
                if (warm_q == '0) begin
                    state_d = StCollect;
                end else if (tick) begin
                    warm_d = warm_q - WarmW'(1);
                    if (warm_q == WarmW'(1)) state_d = StCollect;
                end
            end
            StCollect: begin
                trng_en = 1'b1;
                if (tick) begin
                    pair_vld_d = !pair_vld_q;
                    pair_bit_d = trng_in;
                    if (emit) begin
                        if (bitcnt_inc == BitW'(WORD_WIDTH)) begin
                            if (push_ok) begin
                                push     = 1'b1;
                                word_d   = '0;
                                bitcnt_d = '0;
                            end else begin
                                state_d  = StStall;
                                word_d   = word_shift;
                                bitcnt_d = bitcnt_inc;
                            end
                        end else begin
                            word_d   = word_shift;
                            bitcnt_d = bitcnt_inc;
                        end
                    end
                end
            end
            StStall: begin
                trng_en = 1'b1;
                if (push_ok) begin
                    push       = 1'b1;
                    state_d    = StCollect;
                    word_d     = '0;
                    bitcnt_d   = '0;
                    pair_vld_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Repetition count runs on raw samples, before debiasing
        if (tick) begin
            prev_d = trng_in;
            if (run_q == '0 || trng_in != prev_q) begin
                run_d = RunW'(1);
            end else if (run_q != RunW'(REP_LIMIT)) begin
                run_d = run_q + RunW'(1);
            end
            if (run_d == RunW'(REP_LIMIT)) fail_d = 1'b1;
        end

        if (!enable) begin
            state_d    = StIdle;
            push       = 1'b0;
            div_d      = '0;
            warm_d     = '0;
            pair_vld_d = 1'b0;
            word_d     = '0;
            bitcnt_d   = '0;
            run_d      = '0;
            fail_d     = fail_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            div_q      <= '0;
            warm_q     <= '0;
            pair_vld_q <= 1'b0;
            pair_bit_q <= 1'b0;
            word_q     <= '0;
            bitcnt_q   <= '0;
            prev_q     <= 1'b0;
            run_q      <= '0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            warm_q     <= warm_d;
            pair_vld_q <= pair_vld_d;
            pair_bit_q <= pair_bit_d;
            word_q     <= word_d;
            bitcnt_q   <= bitcnt_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            fail_q     <= fail_d;
        end
    end

    trng_word_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (word_d == '0 && state_q == StStall ? word_q : word_shift),
        .pop_i   (pop),
        .rdata_o (rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_level)
    );

endmodule

// File: tb/tb_trng_collector.sv
// Scoreboard bench: two collector instances (SAMPLE_DIV=1 / SAMPLE_DIV=4) with directed bit streams.
module tb_trng_collector;
    import trng_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_a, in_a, rdy_a, trng_en_a, valid_a, hf_a;
    logic [7:0] data_a;
    logic [1:0] fill_a;
    logic       en_b, in_b, rdy_b, trng_en_b, valid_b, hf_b;
    logic [7:0] data_b;
    logic [2:0] fill_b;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    trng_collector #(
        .WORD_WIDTH (8), .FIFO_DEPTH (2), .SAMPLE_DIV (1), .WARMUP (2), .REP_LIMIT (8)
    ) dut_a (
        .clk (clk), .reset (reset), .enable (en_a), .trng_en (trng_en_a), .trng_in (in_a),
        .rd_valid (valid_a), .rd_ready (rdy_a), .rd_data (data_a), .fill_level (fill_a),
        .health_fail (hf_a)
    );

    trng_collector #(
        .WORD_WIDTH (8), .FIFO_DEPTH (4), .SAMPLE_DIV (4), .WARMUP (2), .REP_LIMIT (8)
    ) dut_b (
        .clk (clk), .reset (reset), .enable (en_b), .trng_en (trng_en_b), .trng_in (in_b),
        .rd_valid (valid_b), .rd_ready (rdy_b), .rd_data (data_b), .fill_level (fill_b),
        .health_fail (hf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && valid_a && rdy_a) begin
                if (q_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_a: got unexpected word %0h expected none", data_a);
                end else begin
                    exp = q_a.pop_front();
                    check("sb_a_word", 32'(data_a), 32'(exp));
                end
            end
            if (!reset && valid_b && rdy_b) begin
                if (q_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_b: got unexpected word %0h expected none", data_b);
                end else begin
                    exp = q_b.pop_front();
                    check("sb_b_word", 32'(data_b), 32'(exp));
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_a(input logic b);
        in_a = b;
        cycle();
    endtask

    // Feed the top nbits of w as debias pairs (bit b -> pair b,~b), optionally with 00/11 junk
    task automatic feed_a(input logic [7:0] w, input int nbits, input bit junk);
        logic jb = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (junk) begin
                tick_a(jb);
                tick_a(jb);
                jb = ~jb;
            end
            tick_a(w[7-i]);
            tick_a(~w[7-i]);
        end
    endtask

    task automatic idle_a();
        en_a = 1'b0;
        cycle();
    endtask

    task automatic start_a();
        en_a = 1'b1;
        cycle();
        tick_a(1'b1);
        tick_a(1'b0);
    endtask

    task automatic drain_a(input int n);
        rdy_a = 1'b1;
        for (int i = 0; i < n; i++) tick_a(i[0]);
        rdy_a = 1'b0;
    endtask

    initial begin
        logic [17:0] seq_b;
        logic [7:0]  wb;

        fork
            monitor();
        join_none

        reset = 1'b1;
        en_a = 1'b0; in_a = 1'b0; rdy_a = 1'b0;
        en_b = 1'b0; in_b = 1'b0; rdy_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_trng_en", 32'(trng_en_a), 0);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_data", 32'(data_a), 0);
        check("rst_fill", 32'(fill_a), 0);
        check("rst_health", 32'(hf_a), 0);

        // Word 1: last pair completes -> rd_valid the next cycle
        start_a();
        check("warm_trng_en", 32'(trng_en_a), 1);
        q_a.push_back(8'hB2);
        feed_a(8'hB2, 7, 1'b0);
        tick_a(1'b0);
        check("w1_valid_early", 32'(valid_a), 0);
        tick_a(1'b1);
        check("w1_valid", 32'(valid_a), 1);
        check("w1_data", 32'(data_a), 32'h0000_00B2);
        check("w1_fill", 32'(fill_a), 1);

        // Word 2 with 00/11 pairs interleaved; they must add no bits
        q_a.push_back(8'h55);
        feed_a(8'h55, 8, 1'b1);
        check("w2_fill", 32'(fill_a), 2);

        // Word 3 into a full FIFO -> stall, then pop and push in one cycle
        q_a.push_back(8'h0F);
        feed_a(8'h0F, 8, 1'b0);
        check("stall_state", 32'(dut_a.state_q), 32'(StStall));
        check("stall_fill", 32'(fill_a), 2);
        check("stall_trng_en", 32'(trng_en_a), 1);
        check("stall_head_held", 32'(data_a), 32'h0000_00B2);
        tick_a(1'b1);
        tick_a(1'b0);
        check("stall_still", 32'(dut_a.state_q), 32'(StStall));
        rdy_a = 1'b1;
        cycle();
        rdy_a = 1'b0;
        check("swap_fill", 32'(fill_a), 2);
        check("swap_state", 32'(dut_a.state_q), 32'(StCollect));
        check("swap_head", 32'(data_a), 32'h0000_0055);
        drain_a(2);
        check("drain_fill", 32'(fill_a), 0);
        check("drain_valid", 32'(valid_a), 0);
        check("drain_data", 32'(data_a), 0);

        // Enable drop with a 5-bit partial word: partial lost, FIFO kept
        idle_a();
        start_a();
        q_a.push_back(8'hC3);
        feed_a(8'hC3, 8, 1'b0);
        feed_a(8'hA8, 5, 1'b0);
        idle_a();
        check("drop_trng_en", 32'(trng_en_a), 0);
        check("drop_fill", 32'(fill_a), 1);
        check("drop_data", 32'(data_a), 32'h0000_00C3);
        start_a();
        q_a.push_back(8'h3C);
        feed_a(8'h3C, 8, 1'b0);
        check("after_drop_fill", 32'(fill_a), 2);
        drain_a(2);
        check("after_drop_empty", 32'(fill_a), 0);

        // Repetition count: 7 ones pass, 8th trips; sticky until IDLE->WARMUP
        idle_a();
        start_a();
        check("hf_clear", 32'(hf_a), 0);
        for (int i = 0; i < 7; i++) tick_a(1'b1);
        check("hf_run7", 32'(hf_a), 0);
        tick_a(1'b1);
        check("hf_run8", 32'(hf_a), 1);
        for (int i = 0; i < 6; i++) tick_a(i[0]);
        check("hf_sticky", 32'(hf_a), 1);
        idle_a();
        check("hf_idle_kept", 32'(hf_a), 1);
        en_a = 1'b1;
        cycle();
        check("hf_reenable", 32'(hf_a), 0);
        tick_a(1'b1);
        tick_a(1'b0);

        // Trip again, keep collecting, then reset mid-COLLECT with 2 words buffered
        for (int i = 0; i < 8; i++) tick_a(1'b1);
        check("hf_trip2", 32'(hf_a), 1);
        feed_a(8'hA5, 8, 1'b0);
        feed_a(8'h5A, 8, 1'b0);
        check("pre_rst_fill", 32'(fill_a), 2);
        feed_a(8'hE0, 3, 1'b0);
        reset = 1'b1;
        cycle();
        check("mrst_valid", 32'(valid_a), 0);
        check("mrst_fill", 32'(fill_a), 0);
        check("mrst_trng_en", 32'(trng_en_a), 0);
        check("mrst_health", 32'(hf_a), 0);
        reset = 1'b0;
        en_a = 1'b0;
        cycle();

        // SAMPLE_DIV=4: only phase 3 of each 4-cycle window carries the intended bit
        wb = 8'h6D;
        seq_b[0] = 1'b0;
        seq_b[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            seq_b[2+2*k] = wb[7-k];
            seq_b[3+2*k] = ~wb[7-k];
        end
        q_b.push_back(wb);
        en_b = 1'b1;
        cycle();
        for (int s = 0; s < 18; s++) begin
            for (int p = 0; p < 4; p++) begin
                if (s == 17 && p == 3) check("b_valid_early", 32'(valid_b), 0);
                in_b = (p == 3) ? seq_b[s] : ~seq_b[s];
                cycle();
            end
        end
        check("b_valid", 32'(valid_b), 1);
        check("b_data", 32'(data_b), 32'h0000_006D);
        check("b_health", 32'(hf_b), 0);
        rdy_b = 1'b1;
        cycle();
        rdy_b = 1'b0;
        en_b = 1'b0;
        cycle();
        check("b_fill", 32'(fill_b), 0);

        repeat (3) cycle();
        check("sb_a_empty", 32'(q_a.size()), 0);
        check("sb_b_empty", 32'(q_b.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
- Consumer end of the TRNG bit stream.
- Enables the oscillator block and samples its single-bit output at a programmable rate.
- Debiases the samples (von Neumann), packs them into words and buffers them in a small FIFO.
- Software reads words through a valid/ready interface; a repetition-count health monitor flags stuck sources.

Parameters:
- WORD_WIDTH, 32, bits per output word (>=2)
- FIFO_DEPTH, 4, words buffered (power of two, >=2)
- SAMPLE_DIV, 4, sample trng_in once every SAMPLE_DIV clk cycles (>=1)
- WARMUP, 16, raw samples discarded after enable
- REP_LIMIT, 8, identical consecutive raw samples that trip health_fail (>=2)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-high
- enable  input  1  collector enable
- trng_en  output  1  enable to the oscillator block
- trng_in  input  1  sampled TRNG bit (already registered at source)
- rd_valid  output  1  FIFO non-empty
- rd_ready  input  1  consumer accepts rd_data
- rd_data  output  WORD_WIDTH  FIFO head word
- fill_level  output  $clog2(FIFO_DEPTH)+1  words in FIFO
- health_fail  output  1  sticky repetition-count failure

Behaviour:
- Reset values: trng_en=0, rd_valid=0, rd_data=0, fill_level=0, health_fail=0. FIFO is emptied, all counters are zeroed, state=IDLE.
- State machine:
  - IDLE:
    - trng_en=0.
    - enable=1 -> WARMUP.
  - WARMUP:
    - trng_en=1, divider runs.
    - Each sample tick decrements the warmup counter; samples are discarded.
    - After WARMUP ticks -> COLLECT.
  - COLLECT:
    - On each tick, trng_in is latched as half of a debias pair.
    - On the second bit of a pair: 01 emits 0, 10 emits 1, 00/11 emit nothing. The pair is then cleared.
    - An emitted bit shifts in at the LSB: word <= {word[W-2:0], bit}; bitcnt++.
    - When bitcnt reaches WORD_WIDTH, the word is pushed the same cycle if a push is allowed (bitcnt cleared, stay in COLLECT); otherwise -> STALL.
  - STALL:
    - Completed word is held; divider stops; trng_en stays 1.
    - Push on the first cycle it is allowed, then -> COLLECT with bitcnt=0 and the pair cleared.
- Any state:
  - enable=0 -> IDLE next cycle; the partial word, pair and counters are discarded. FIFO contents and health_fail are retained.
- Sample tick: divider counts 0..SAMPLE_DIV-1; tick when count==SAMPLE_DIV-1. SAMPLE_DIV=1 ticks every cycle. Divider is cleared on entering WARMUP.
- FIFO:
  - Push allowed when fill_level<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Pop when rd_valid&&rd_ready.
  - Simultaneous push/pop leaves fill_level unchanged.
  - rd_data is the head word, valid the cycle rd_valid=1. It is held stable while rd_valid&&!rd_ready and is 0 when empty.
  - Latency: last accepted bit to rd_valid=1 with an empty FIFO is 1 cycle.
- Health monitor:
  - Active in WARMUP and COLLECT, on raw ticks (before debias).
  - Run counter resets to 1 when a sample differs from the previous one.
  - Run reaching REP_LIMIT sets health_fail.
  - health_fail clears only on reset or the IDLE->WARMUP transition.
  - Collection continues while health_fail=1; software decides whether to discard data.

Decomposition:
- Package trng_pkg:
  - collector_state_t enum (IDLE, WARMUP, COLLECT, STALL)
  - default-parameter constants
  - debias encoding constants
- Sub-module trng_word_fifo:
  - parameters WIDTH, DEPTH
  - push/pop/full/empty/count, synchronous reset
  - instantiated once

Test Plan:
- Reset mid-COLLECT with 2 words in FIFO -> next cycle rd_valid=0, fill_level=0, trng_en=0, health_fail=0.
- SAMPLE_DIV=1, WARMUP=2, WORD_WIDTH=8:
  - Drive 2 discard bits, then pairs 10,01,10,10,01,01,10,01 -> one word 8'b10110010; rd_valid rises 1 cycle after the last pair.
  - Drive interleaved 00/11 pairs -> word unchanged, no extra bits.
- FIFO_DEPTH=2, rd_ready=0, feed 3 words -> fill_level=2, state STALL holding word 3, trng_en=1. Assert rd_ready for 1 cycle -> pop word 1 and push word 3 the same cycle, fill_level stays 2.
- REP_LIMIT=8: drive 7 consecutive 1s -> health_fail=0; 8th -> health_fail=1. Remains 1 after the pattern resumes toggling; clears after enable 0->1.
- SAMPLE_DIV=4: toggle trng_in every cycle -> only every 4th cycle's value enters the pair logic (check via emitted bits).
- enable dropped with bitcnt=5 -> IDLE, partial word lost, FIFO words retained and still readable.
